// File: rtl/noc_eject_receiver_pkg.sv
// Shared flit encodings, HEAD field layout and receiver FSM states for the mesh eject path.
package noc_eject_receiver_pkg;

  localparam int FLIT_W_FIXED = 16;

  localparam logic [1:0] FT_BODY     = 2'b00;
  localparam logic [1:0] FT_HEAD     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  // Packed so that the struct overlays flit[13:0] directly: src, dst, len, seq.
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] len;
    logic [5:0] seq;
  } head_t;

  typedef enum logic [1:0] {
    S_HEAD  = 2'd0,
    S_BODY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic head_t parse_head(input logic [13:0] fields);
    return head_t'(fields);
  endfunction

endpackage

// File: rtl/noc_eject_receiver.sv
// Eject-port sink: parses flits, validates framing/destination/sequence, XOR-checksums payload.
// Completion outputs are registered one cycle after the tail; only sink_stall backpressures.
module noc_eject_receiver
  import noc_eject_receiver_pkg::*;
#(
  parameter logic [1:0] NODE_ID = 2'd0,
  parameter int         FLIT_W  = FLIT_W_FIXED,
  parameter int         CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flit_in_valid,
  input  logic [FLIT_W-1:0] flit_in,
  output logic              flit_in_ready,
  input  logic              sink_stall,
  input  logic              expect_en,
  input  logic [CNT_W-1:0]  expect_count,
  output logic              pkt_done,
  output logic [1:0]        pkt_src,
  output logic [13:0]       pkt_checksum,
  output logic [CNT_W-1:0]  rx_count,
  output logic              err_dst,
  output logic              err_proto,
  output logic              err_seq,
  output logic              processor_ready
);

  state_t      state, state_nxt;
  head_t       cur, hd;
  logic [3:0]  cnt;
  logic [13:0] chk;
  logic [5:0]  exp_seq [4];

  logic        acc, is_head, proto, cmp, latch, body_upd;
  logic [1:0]  typ;
  logic [13:0] payload;
  head_t       cmp_hdr;
  logic [13:0] cmp_chk;
  logic [4:0]  cnt_inc;

  assign flit_in_ready = reset & ~sink_stall;
  assign acc           = flit_in_valid & flit_in_ready;
  assign typ           = flit_in[15:14];
  assign payload       = flit_in[13:0];
  assign hd            = parse_head(flit_in[13:0]);
  assign is_head       = (typ == FT_HEAD) || (typ == FT_HEADTAIL);
  assign cnt_inc       = {1'b0, cnt} + 5'd1;

  always_comb begin
    state_nxt = state;
    proto     = 1'b0;
    cmp       = 1'b0;
    latch     = 1'b0;
    body_upd  = 1'b0;
    cmp_hdr   = cur;
    cmp_chk   = chk ^ payload;
    if (acc) begin
      if (is_head) begin
        // A head arriving mid-packet abandons the open packet, then starts afresh.
        proto = (state == S_BODY);
        if (typ == FT_HEADTAIL) begin
          cmp       = 1'b1;
          cmp_hdr   = hd;
          cmp_chk   = '0;
          state_nxt = S_HEAD;
        end else if (hd.len == 4'd0) begin
          proto     = 1'b1;
          state_nxt = S_DRAIN;
        end else begin
          latch     = 1'b1;
          state_nxt = S_BODY;
        end
      end else begin
        case (state)
          S_HEAD: proto = 1'b1;
          S_BODY: begin
            if (typ == FT_TAIL) begin
              state_nxt = S_HEAD;
              if (cnt_inc == {1'b0, cur.len}) cmp = 1'b1;
              else                            proto = 1'b1;
            end else if (cnt_inc >= {1'b0, cur.len}) begin
              proto     = 1'b1;
              state_nxt = S_DRAIN;
            end else begin
              body_upd = 1'b1;
            end
          end
          S_DRAIN: if (typ == FT_TAIL) state_nxt = S_HEAD;
          default: state_nxt = S_HEAD;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_HEAD;
      cur             <= '0;
      cnt             <= '0;
      chk             <= '0;
      for (int i = 0; i < 4; i++) exp_seq[i] <= '0;
      pkt_done        <= 1'b0;
      pkt_src         <= '0;
      pkt_checksum    <= '0;
      rx_count        <= '0;
      err_dst         <= 1'b0;
      err_proto       <= 1'b0;
      err_seq         <= 1'b0;
      processor_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      pkt_done  <= cmp;
      err_proto <= proto;
      err_dst   <= cmp && (cmp_hdr.dst != NODE_ID);
      err_seq   <= cmp && (cmp_hdr.dst == NODE_ID) && (cmp_hdr.seq != exp_seq[cmp_hdr.src]);
      if (latch) begin
        cur <= hd;
        cnt <= '0;
        chk <= '0;
      end else if (body_upd) begin
        cnt <= cnt_inc[3:0];
        chk <= chk ^ payload;
      end
      if (cmp) begin
        pkt_src      <= cmp_hdr.src;
        pkt_checksum <= cmp_chk;
      end
      if (cmp && (cmp_hdr.dst == NODE_ID)) exp_seq[cmp_hdr.src] <= cmp_hdr.seq + 6'd1;
      // Counter is pinned at zero while configuration is inactive.
      if (!expect_en)
        rx_count <= '0;
      else if (cmp && (cmp_hdr.dst == NODE_ID) && !(&rx_count))
        rx_count <= rx_count + 1'b1;
      processor_ready <= expect_en && (rx_count >= expect_count);
    end
  end

endmodule

// File: tb/tb_noc_eject_receiver.sv
// Scoreboard bench for noc_eject_receiver at NODE_ID=1.
module tb_noc_eject_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        flit_in_valid;
  logic [15:0] flit_in;
  logic        flit_in_ready;
  logic        sink_stall;
  logic        expect_en;
  logic [7:0]  expect_count;
  logic        pkt_done;
  logic [1:0]  pkt_src;
  logic [13:0] pkt_checksum;
  logic [7:0]  rx_count;
  logic        err_dst, err_proto, err_seq, processor_ready;

  noc_eject_receiver #(.NODE_ID(2'd1), .FLIT_W(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .flit_in_valid(flit_in_valid), .flit_in(flit_in),
    .flit_in_ready(flit_in_ready), .sink_stall(sink_stall), .expect_en(expect_en),
    .expect_count(expect_count), .pkt_done(pkt_done), .pkt_src(pkt_src),
    .pkt_checksum(pkt_checksum), .rx_count(rx_count), .err_dst(err_dst),
    .err_proto(err_proto), .err_seq(err_seq), .processor_ready(processor_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  src;
    logic [13:0] chk;
    logic        ed;
    logic        es;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         proto_seen = 0;
  int         proto_exp = 0;
  logic [5:0] m_exp [4];
  int         m_rx = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hd(input logic [1:0] s, input logic [1:0] d,
                                     input logic [3:0] l, input logic [5:0] q);
    return {2'b01, s, d, l, q};
  endfunction
  function automatic logic [15:0] ht(input logic [1:0] s, input logic [1:0] d, input logic [5:0] q);
    return {2'b11, s, d, 4'd0, q};
  endfunction
  function automatic logic [15:0] bd(input logic [13:0] p); return {2'b00, p}; endfunction
  function automatic logic [15:0] tl(input logic [13:0] p); return {2'b10, p}; endfunction

  // Reference behaviour of a completed packet at node 1.
  task automatic expect_done(input logic [1:0] s, input logic [1:0] d, input logic [5:0] q,
                             input logic [13:0] c);
    exp_t e;
    e.src = s; e.chk = c; e.ed = (d != 2'd1); e.es = 1'b0;
    if (!e.ed) begin
      e.es = (q != m_exp[s]);
      m_exp[s] = q + 6'd1;
      if (m_rx < 255) m_rx++;
    end
    sb.push_back(e);
  endtask

  task automatic send_flit(input logic [15:0] f);
    bit done = 0;
    @(negedge clock);
    flit_in_valid = 1'b1;
    flit_in = f;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clock);
      if (flit_in_ready) done = 1;
    end
    if (!done) check_eq("send_timeout", 0, 1);
    #1 flit_in_valid = 1'b0;
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) @(posedge clock);
    #1;
    check_eq({tag, "_rx"}, rx_count, m_rx);
    check_eq({tag, "_proto"}, proto_seen, proto_exp);
  endtask

  always @(negedge clock) begin
    if (err_proto) proto_seen++;
    if (pkt_done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("pkt_src", pkt_src, e.src);
        check_eq("pkt_checksum", pkt_checksum, e.chk);
        check_eq("err_dst", err_dst, e.ed);
        check_eq("err_seq", err_seq, e.es);
      end
    end else begin
      if (err_dst || err_seq) check_eq("err_without_done", {err_dst, err_seq}, 0);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) m_exp[i] = '0;
    reset = 1'b0; flit_in_valid = 1'b0; flit_in = '0; sink_stall = 1'b0;
    expect_en = 1'b0; expect_count = 8'd2;
    #12;
    check_eq("rst_ready", flit_in_ready, 0);
    check_eq("rst_outs", {pkt_done, err_dst, err_proto, err_seq, processor_ready}, 0);
    check_eq("rst_rx", rx_count, 0);
    @(negedge clock); reset = 1'b1; expect_en = 1'b1;
    #1 check_eq("ready_after_rst", flit_in_ready, 1);

    // 1: two good packets reach expect_count
    send_flit(hd(2'd2, 2'd1, 4'd2, 6'd0));
    send_flit(bd(14'h0005));
    send_flit(tl(14'h0003));
    expect_done(2'd2, 2'd1, 6'd0, 14'h0006);
    send_flit(ht(2'd2, 2'd1, 6'd1));
    expect_done(2'd2, 2'd1, 6'd1, 14'h0000);
    check_eq("t1_rx_now", rx_count, 2);
    check_eq("t1_ready_lag", processor_ready, 0);
    @(posedge clock); #1;
    check_eq("t1_ready", processor_ready, 1);
    settle_and_check("t1");

    // 2: wrong destination
    send_flit(hd(2'd0, 2'd3, 4'd1, 6'd0));
    send_flit(tl(14'h0011));
    expect_done(2'd0, 2'd3, 6'd0, 14'h0011);
    settle_and_check("t2");

    // 3: short tail, then overlong body drained, then a good packet
    send_flit(hd(2'd1, 2'd1, 4'd3, 6'd0));
    send_flit(bd(14'h000a));
    send_flit(tl(14'h000b));
    proto_exp++;
    send_flit(hd(2'd1, 2'd1, 4'd1, 6'd0));
    send_flit(bd(14'h0001));
    proto_exp++;
    send_flit(bd(14'h0002));
    send_flit(tl(14'h0003));
    send_flit(hd(2'd1, 2'd1, 4'd1, 6'd0));
    send_flit(tl(14'h0007));
    expect_done(2'd1, 2'd1, 6'd0, 14'h0007);
    settle_and_check("t3");

    // 4: sequence gap then resync
    send_flit(hd(2'd3, 2'd1, 4'd1, 6'd0));
    send_flit(tl(14'h0001));
    expect_done(2'd3, 2'd1, 6'd0, 14'h0001);
    send_flit(ht(2'd3, 2'd1, 6'd5));
    expect_done(2'd3, 2'd1, 6'd5, 14'h0000);
    send_flit(ht(2'd3, 2'd1, 6'd6));
    expect_done(2'd3, 2'd1, 6'd6, 14'h0000);
    settle_and_check("t4");

    // 5: stall while a body flit is held
    send_flit(hd(2'd0, 2'd1, 4'd2, 6'd0));
    @(negedge clock); sink_stall = 1'b1;
    fork
      send_flit(bd(14'h0100));
      begin
        @(negedge clock); #1;
        check_eq("t5_stall_ready", flit_in_ready, 0);
        repeat (2) @(negedge clock);
        sink_stall = 1'b0;
      end
    join
    send_flit(tl(14'h00ff));
    expect_done(2'd0, 2'd1, 6'd0, 14'h01ff);
    settle_and_check("t5");

    // 6: reset mid-packet, then recovery; expect_en controls the counter
    send_flit(hd(2'd0, 2'd1, 4'd3, 6'd1));
    send_flit(bd(14'h0022));
    @(negedge clock); reset = 1'b0;
    #1;
    check_eq("t6_rst_outs", {pkt_done, err_dst, err_proto, err_seq, processor_ready, flit_in_ready}, 0);
    check_eq("t6_rst_rx", rx_count, 0);
    check_eq("t6_rst_chk", {pkt_src, pkt_checksum}, 0);
    for (int i = 0; i < 4; i++) m_exp[i] = '0;
    m_rx = 0;
    @(negedge clock); reset = 1'b1;
    send_flit(hd(2'd0, 2'd1, 4'd1, 6'd0));
    send_flit(tl(14'h0009));
    expect_done(2'd0, 2'd1, 6'd0, 14'h0009);
    settle_and_check("t6");
    @(negedge clock); expect_en = 1'b0; m_rx = 0;
    repeat (2) @(posedge clock); #1;
    check_eq("t6_en_rx", rx_count, 0);
    check_eq("t6_en_ready", processor_ready, 0);
    @(negedge clock); expect_count = 8'd0; expect_en = 1'b1;
    @(posedge clock); #1;
    check_eq("t6_cnt0_ready", processor_ready, 1);

    repeat (3) @(posedge clock); #1;
    check_eq("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
